// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer. The divided clock tick_clk is resynchronized as data into
// a sample tick. Optional long-press strobes are enabled by defining DEBOUNCE_LONG_PRESS_EN.
module button_debouncer #(
  parameter int CHANNELS     = 4,
  parameter int STABLE_TICKS = 4,
  parameter int LONG_TICKS   = 100
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                tick_clk,
  input  logic [CHANNELS-1:0] btn_raw,
  output logic [CHANNELS-1:0] btn_state,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_long
);

  localparam int            CW       = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  if (CHANNELS < 1 || STABLE_TICKS < 1 || LONG_TICKS < 1) begin : g_param_check
    $error("button_debouncer: CHANNELS, STABLE_TICKS and LONG_TICKS must all be >= 1");
  end

  logic                tk_s1, tk_s2, tk_prev;
  logic [CHANNELS-1:0] btn_s1, btn_sync;
  logic                sample_tick;

  // NOTE: every flop uses non-blocking assignment so each stage samples its pre-edge input;
  // blocking here would collapse the synchronizer chain into a single stage.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      tk_s1    <= 1'b0;
      tk_s2    <= 1'b0;
      tk_prev  <= 1'b0;
      btn_s1   <= '0;
      btn_sync <= '0;
    end else begin
      tk_s1    <= tick_clk;
      tk_s2    <= tk_s1;
      tk_prev  <= tk_s2;
      btn_s1   <= btn_raw;
      btn_sync <= btn_s1;
    end
  end

  // One clk_in cycle per rising edge of the divided clock.
  assign sample_tick = tk_s2 & ~tk_prev;

  logic [CW-1:0] cnt [CHANNELS];

  // NOTE: the count array is a few flops per channel, not a RAM, so it is reset with everything
  // else; a stale count surviving reset would let a press be accepted early.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      btn_state   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else begin
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        if (btn_sync[i] == btn_state[i]) begin
          cnt[i] <= '0;
        end else if (sample_tick) begin
          if (cnt[i] == CNT_LAST) begin
            // Strobe is registered alongside the new level so both appear in the same cycle.
            btn_state[i]   <= ~btn_state[i];
            btn_press[i]   <= ~btn_state[i];
            btn_release[i] <= btn_state[i];
            cnt[i]         <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int            LW       = $clog2(LONG_TICKS + 1);
  localparam logic [LW-1:0] HOLD_MAX = LW'(LONG_TICKS);

  logic [LW-1:0] hold_cnt [CHANNELS];

  always_ff @(posedge clk_in) begin
    if (rst) begin
      btn_long <= '0;
      for (int i = 0; i < CHANNELS; i++) hold_cnt[i] <= '0;
    end else begin
      btn_long <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        if (!btn_state[i]) begin
          hold_cnt[i] <= '0;
        end else if (sample_tick && hold_cnt[i] != HOLD_MAX) begin
          // Saturating at HOLD_MAX makes the strobe fire exactly once per press.
          hold_cnt[i] <= hold_cnt[i] + 1'b1;
          btn_long[i] <= (hold_cnt[i] == HOLD_MAX - 1'b1);
        end
      end
    end
  end
`else
  assign btn_long = '0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed sequences, a vector table and randomized
// button activity compared cycle by cycle against a tick-counting reference model.
module tb_button_debouncer;

  localparam int CH   = 4;
  localparam int ST   = 4;
  localparam int LT   = 10;
  localparam int HALF = 10;   // tick_clk half period in clk_in cycles
`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int EXP_LONG_PULSES = 1;
  localparam int EXP_LONG_TICKS  = LT;
`else
  localparam int EXP_LONG_PULSES = 0;
  localparam int EXP_LONG_TICKS  = -1;
`endif

  logic          clk_in   = 1'b0;
  logic          rst      = 1'b1;
  logic          tick_clk = 1'b0;
  logic [CH-1:0] btn_raw  = '1;
  logic [CH-1:0] btn_state, btn_press, btn_release, btn_long;

  int errors = 0;
  int checks = 0;
  int rises  = 0;
  bit sb_on  = 1'b0;

  button_debouncer #(
    .CHANNELS    (CH),
    .STABLE_TICKS(ST),
    .LONG_TICKS  (LT)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .tick_clk   (tick_clk),
    .btn_raw    (btn_raw),
    .btn_state  (btn_state),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  always #5 clk_in = ~clk_in;

  initial forever begin
    repeat (HALF) @(posedge clk_in);
    #1 tick_clk = ~tick_clk;
  end

  always @(posedge tick_clk) rises++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: inputs reach the debouncer two edges after they are sampled; a tick is seen
  // two edges after a tick_clk rise. A level is accepted on the ST-th tick since it last agreed.
  logic [CH-1:0] m_state = '0, m_press = '0, m_release = '0, m_long = '0;
  int            run  [CH];
  int            held [CH];
  logic [CH-1:0] raw_q [$] = '{'0, '0};
  bit            tk_q  [$] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk_in) begin : model
    logic [CH-1:0] sync;
    bit            tick;
    sync      = raw_q[0];
    tick      = tk_q[1] & ~tk_q[0];
    m_press   = '0;
    m_release = '0;
    m_long    = '0;
    if (rst) begin
      m_state = '0;
      for (int i = 0; i < CH; i++) begin
        run[i]  = 0;
        held[i] = 0;
      end
      raw_q = '{'0, '0};
      tk_q  = '{1'b0, 1'b0, 1'b0};
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (!m_state[i]) held[i] = 0;
        else if (tick) begin
          held[i]++;
          if (held[i] == LT) m_long[i] = 1'b1;
        end
        if (sync[i] == m_state[i]) run[i] = 0;
        else if (tick) begin
          run[i]++;
          if (run[i] == ST) begin
            m_press[i]   = ~m_state[i];
            m_release[i] = m_state[i];
            m_state[i]   = ~m_state[i];
            run[i]       = 0;
          end
        end
      end
      raw_q.push_back(btn_raw);
      void'(raw_q.pop_front());
      tk_q.push_back(tick_clk);
      void'(tk_q.pop_front());
    end
    sb_on = 1'b1;
  end

  always @(negedge clk_in) begin
    if (sb_on) begin
      check("sb_state",   btn_state,   m_state);
      check("sb_press",   btn_press,   m_press);
      check("sb_release", btn_release, m_release);
      check("sb_long",    btn_long,    (EXP_LONG_PULSES != 0) ? m_long : '0);
    end
  end

  // Place the bench mid-way through the low phase, 8 cycles before the next tick_clk rise.
  task automatic align_low();
    @(negedge tick_clk);
    repeat (2) @(posedge clk_in);
    #1;
  endtask

  // sel: 0 press, 1 release, 2 long. Returns on the negedge where the strobe is seen.
  task automatic wait_strobe(input int sel, input logic [CH-1:0] mask, input string name,
                             input int max_cyc);
    bit hit = 1'b0;
    for (int c = 0; c < max_cyc && !hit; c++) begin
      @(negedge clk_in);
      case (sel)
        0:       hit = |(btn_press & mask);
        1:       hit = |(btn_release & mask);
        default: hit = |(btn_long & mask);
      endcase
    end
    if (!hit) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic settle(input int cyc);
    repeat (cyc) @(posedge clk_in);
    #1;
  endtask

  typedef struct {
    logic [CH-1:0] raw;
    int            hold;
    logic [CH-1:0] exp_state;
  } vec_t;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    vec_t vecs [9];
    int   r0, bad, nlong, long_ticks;

    vecs[0] = '{4'b0001, 5, 4'b0001};
    vecs[1] = '{4'b0011, 5, 4'b0011};
    vecs[2] = '{4'b1010, 5, 4'b1010};
    vecs[3] = '{4'b1111, 5, 4'b1111};
    vecs[4] = '{4'b0000, 5, 4'b0000};
    vecs[5] = '{4'b0110, 2, 4'b0000};
    vecs[6] = '{4'b1001, 5, 4'b1001};
    vecs[7] = '{4'b0101, 5, 4'b0101};
    vecs[8] = '{4'b0000, 5, 4'b0000};

    // Reset with all buttons pressed: outputs stay 0 during reset and the cycle after.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_in);
      check("reset_outputs", {btn_state, btn_press, btn_release, btn_long}, 32'd0);
    end
    rst     = 1'b0;
    btn_raw = '0;
    @(negedge clk_in);
    check("post_reset_outputs", {btn_state, btn_press, btn_release, btn_long}, 32'd0);

    // Clean press and release on channel 0.
    align_low();
    r0 = rises;
    btn_raw[0] = 1'b1;
    wait_strobe(0, 4'b0001, "press0", 200);
    check("press0_ticks", rises - r0, ST);
    check("press0_state", btn_state[0], 1'b1);
    @(negedge clk_in);
    check("press0_width", btn_press[0], 1'b0);
    align_low();
    r0 = rises;
    btn_raw[0] = 1'b0;
    wait_strobe(1, 4'b0001, "release0", 200);
    check("release0_ticks", rises - r0, ST);
    check("release0_state", btn_state[0], 1'b0);
    @(negedge clk_in);
    check("release0_width", btn_release[0], 1'b0);

    // Bounce on channel 1 every 30 cycles: never accepted.
    align_low();
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      if (c % 30 == 0) btn_raw[1] = ~btn_raw[1];
      @(negedge clk_in);
      if (btn_state[1] || btn_press[1] || btn_release[1]) bad++;
    end
    check("bounce_activity", bad, 0);
    align_low();
    r0 = rises;
    btn_raw[1] = 1'b1;
    wait_strobe(0, 4'b0010, "bounce_press", 200);
    check("bounce_press_ticks", rises - r0, ST);
    btn_raw = '0;
    settle(6 * 2 * HALF);
    check("bounce_released", btn_state, 4'b0000);

    // Simultaneous acceptance on channels 3 and 2.
    align_low();
    btn_raw[3:2] = 2'b11;
    wait_strobe(0, 4'b1100, "simul_press", 200);
    check("simul_press_bits", btn_press[3:2], 2'b11);
    btn_raw = '0;
    settle(6 * 2 * HALF);

    // Reset after three ticks of a pending press: four fresh ticks needed afterwards.
    align_low();
    btn_raw[0] = 1'b1;
    repeat (3) @(posedge tick_clk);
    settle(HALF + 1);
    check("midcount_state", btn_state[0], 1'b0);
    rst = 1'b1;
    settle(2);
    rst = 1'b0;
    r0  = rises;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_in);
      check("midcount_no_strobe", {btn_press, btn_release}, 32'd0);
    end
    wait_strobe(0, 4'b0001, "midcount_press", 200);
    check("midcount_ticks", rises - r0, ST);
    btn_raw = '0;
    settle(6 * 2 * HALF);

    // Long press: hold 15 ticks past acceptance.
    align_low();
    btn_raw[0] = 1'b1;
    wait_strobe(0, 4'b0001, "long_press", 200);
    r0         = rises;
    nlong      = 0;
    long_ticks = -1;
    for (int c = 0; c < 15 * 2 * HALF; c++) begin
      @(negedge clk_in);
      if (btn_long[0]) begin
        nlong++;
        if (long_ticks < 0) long_ticks = rises - r0;
      end
    end
    check("long_pulses", nlong, EXP_LONG_PULSES);
    check("long_ticks", long_ticks, EXP_LONG_TICKS);
    btn_raw = '0;
    settle(6 * 2 * HALF);

    // Vector table: apply a level, hold for N ticks, check the accepted levels.
    for (int v = 0; v < 9; v++) begin
      btn_raw = vecs[v].raw;
      repeat (vecs[v].hold) @(posedge tick_clk);
      settle(4);
      check($sformatf("vec%0d_state", v), btn_state, vecs[v].exp_state);
    end

    // Randomized activity with occasional resets; the scoreboard checks every cycle.
    for (int seg = 0; seg < 60; seg++) begin
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        settle($urandom_range(1, 3));
        rst = 1'b0;
      end
      btn_raw = CH'($urandom);
      if ($urandom_range(0, 3) == 0) settle($urandom_range(250, 300));
      else                           settle($urandom_range(5, 140));
    end
    settle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

- Multi-channel push-button debouncer for the T20 module.
- Sits directly downstream of the system clock divider. It consumes one divided, 50%-duty clock output as a slow sample reference, for example a clk_out1-class output.
- It resynchronizes that divided clock and the raw buttons into the clk_in domain. It then produces clean button levels plus one-cycle press and release strobes.
- All logic runs on clk_in. The divided clock is never used as a clock.

## Interface
Parameters:
- CHANNELS, 4: number of independent button channels (≥1).
- STABLE_TICKS, 4: number of consecutive sample ticks a changed input must hold before it is accepted (≥1).
- LONG_TICKS, 100: number of sample ticks held pressed before btn_long fires (≥1). Used only with the Configuration macro.

Ports:
- clk_in, input, 1: system clock. Sole clock.
- rst, input, 1: reset. Synchronous, active-high.
- tick_clk, input, 1: divided clock from the clock divider. Treated as asynchronous data.
- btn_raw, input, CHANNELS: raw buttons. Active-high. Asynchronous.
- btn_state, output, CHANNELS: debounced button level.
- btn_press, output, CHANNELS: one-cycle strobe on each 0→1 transition of btn_state.
- btn_release, output, CHANNELS: one-cycle strobe on each 1→0 transition of btn_state.
- btn_long, output, CHANNELS: one-cycle long-press strobe. Tied 0 when the Configuration macro is not defined.

Clocking and reset (already decided): one clock, clk_in; reset rst is synchronous and active-high.

## Operation
- **tick_clk synchronizer:** 2-flop synchronizer (tk_s1, tk_s2), followed by tk_prev <= tk_s2.
- **Sample tick:** sample_tick = tk_s2 & ~tk_prev, decoded combinationally from flops. This gives one clk_in cycle per tick_clk rising edge.
- **Button synchronizer:** btn_raw passes through a per-bit 2-flop synchronizer to give btn_sync.
- **Per-channel counter:** cnt[i], width $clog2(STABLE_TICKS+1), updated each clk_in edge:
  - If btn_sync[i] == btn_state[i]: cnt <= 0. This applies on every cycle, tick or not.
  - Else, if sample_tick and cnt == STABLE_TICKS-1:
    - btn_state[i] toggles.
    - cnt <= 0.
    - btn_press[i] or btn_release[i] <= 1, matching the direction of the toggle.
  - Else, if sample_tick: cnt <= cnt+1.
  - Otherwise cnt holds.
- **Counter range:** cnt never exceeds STABLE_TICKS-1 and never wraps.
- **Strobes:** press and release strobes are registered. They are high for exactly the first cycle in which the new btn_state is visible, and 0 in all other cycles.
- **Bounce rejection:** any bounce that returns btn_sync to btn_state before acceptance discards the accumulated count.
- **Channel independence:** channels are fully independent. Simultaneous acceptance on several channels produces simultaneous strobes.

## Timing
- **Reset values:** all of the following reset to 0: every synchronizer flop, tk_prev, cnt, btn_state, btn_press, btn_release, btn_long.
- **Reset mid-operation:** reset aborts counts and emits no strobe in the reset cycle or the cycle after.
- **tick_clk high at reset release:** exactly one sample tick is generated 2 cycles after release. This is accepted behaviour; a channel's count is at most one tick early.
- **tick_clk latency:** if tick_clk rises before clk_in edge k, sample_tick is high in the cycle following edge k+1.
- **btn_raw latency:** a btn_raw change before edge k is visible in btn_sync after edge k+1.
- **Acceptance latency:** acceptance occurs at the sample tick that completes STABLE_TICKS consecutive differing ticks. btn_state and the strobe update at that clock edge.
- **Tick pulse width:** tick_clk high or low phases must each be ≥2 clk_in cycles. Narrower pulses may be missed.
- **Maximum strobe rate:** one strobe per channel per STABLE_TICKS ticks.

## Configuration
- **Macro:** DEBOUNCE_LONG_PRESS_EN.
- **Defined:**
  - Each channel has a hold counter, width $clog2(LONG_TICKS+1), which resets to 0.
  - While btn_state[i]=1, the counter increments on each sample_tick and saturates at LONG_TICKS.
  - btn_long[i] pulses for one cycle on the tick where the counter reaches LONG_TICKS. It pulses once per press.
  - The counter clears when btn_state[i]=0.
  - A release before LONG_TICKS produces no btn_long.
- **Undefined:** no hold counters. btn_long is constant 0 and LONG_TICKS is ignored.

## Test plan
Bench setup for all scenarios: CHANNELS=4, STABLE_TICKS=4, LONG_TICKS=10, tick_clk period 20 clk_in cycles.

1. **Reset:** assert rst 3 cycles with btn_raw=4'hF. All outputs are 0 during reset and in the cycle after.
2. **Clean press:** hold btn_raw[0]=1. After exactly 4 sample ticks, btn_state[0]=1 and btn_press[0] is high for 1 cycle. After releasing, btn_release[0] fires 4 ticks later.
3. **Bounce:** toggle btn_raw[1] every 30 cycles for 300 cycles. btn_state[1] stays 0 with no strobes. Then hold it at 1: press accepted 4 ticks later.
4. **Simultaneous channels:** raise btn_raw[3:2] on the same cycle. btn_press[3:2]=2'b11 fires in the same cycle.
5. **Reset mid-count:** assert rst after 3 ticks of a pending press on channel 0, then keep btn_raw[0]=1. Acceptance requires 4 fresh ticks after release.
6. **Long press:**
   - With DEBOUNCE_LONG_PRESS_EN, hold 15 ticks after acceptance: btn_long[0] pulses once, 10 ticks after btn_press.
   - Without the macro, btn_long stays 0.
